cache_mem_arbiter: RTL

Two-port arbiter that shares the single off-chip memory bus between the I-cache and D-cache miss/write-back engines, sitting between the two caches and the memory model below the pipeline. Each cache issues level-held read or write block requests. The arbiter grants one at a time with alternating priority on ties, drives registered commands to memory and returns a one-cycle ready pulse plus the captured read block to the granted cache.

---
 rtl/cache_mem_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one off-chip memory bus between the I-cache and D-cache block engines.
// One transfer at a time, alternating priority on ties, registered memory commands.
module cache_mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_mem_read,
  input  logic              I_mem_write,
  input  logic [ADDR_W-1:0] I_mem_addr,
  input  logic [DATA_W-1:0] I_mem_wdata,
  output logic [DATA_W-1:0] I_mem_rdata,
  output logic              I_mem_ready,
  input  logic              D_mem_read,
  input  logic              D_mem_write,
  input  logic [ADDR_W-1:0] D_mem_addr,
  input  logic [DATA_W-1:0] D_mem_wdata,
  output logic [DATA_W-1:0] D_mem_rdata,
  output logic              D_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic                last_grant_r, last_grant_s;
  logic                mem_read_s, mem_write_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [DATA_W-1:0]   resp_r, resp_s;
  logic                i_ready_s, d_ready_s;
  logic                i_req_s, d_req_s, grant_d_s;

  // last_grant=0 means I went last, so D wins the tie
  assign i_req_s   = I_mem_read | I_mem_write;
  assign d_req_s   = D_mem_read | D_mem_write;
  assign grant_d_s = d_req_s & (~i_req_s | ~last_grant_r);

  assign I_mem_rdata = resp_r;
  assign D_mem_rdata = resp_r;

  // Next-state and next-output decode
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    mem_read_s   = mem_read;
    mem_write_s  = mem_write;
    mem_addr_s   = mem_addr;
    mem_wdata_s  = mem_wdata;
    resp_s       = resp_r;
    i_ready_s    = 1'b0;
    d_ready_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_s      = BUSY_D;
          last_grant_s = 1'b1;
          mem_write_s  = D_mem_write;
          mem_read_s   = ~D_mem_write;
          mem_addr_s   = D_mem_addr;
          mem_wdata_s  = D_mem_wdata;
        end else if (i_req_s) begin
          state_s      = BUSY_I;
          last_grant_s = 1'b0;
          mem_write_s  = I_mem_write;
          mem_read_s   = ~I_mem_write;
          mem_addr_s   = I_mem_addr;
          mem_wdata_s  = I_mem_wdata;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          if (mem_read) begin
            resp_s = mem_rdata;
          end else begin
            resp_s = resp_r;
          end
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          i_ready_s   = (state_r == BUSY_I);
          d_ready_s   = (state_r == BUSY_D);
          state_s     = RESP;
        end else begin
          state_s = state_r;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
      resp_r       <= {DATA_W{1'b0}};
      I_mem_ready  <= 1'b0;
      D_mem_ready  <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      mem_read     <= mem_read_s;
      mem_write    <= mem_write_s;
      mem_addr     <= mem_addr_s;
      mem_wdata    <= mem_wdata_s;
      resp_r       <= resp_s;
      I_mem_ready  <= i_ready_s;
      D_mem_ready  <= d_ready_s;
    end
  end

endmodule
